// File: rtl/reorder_buffer_pkg.sv
// reorder_buffer_pkg: default sizes and entry type encodings for the reorder buffer
package reorder_buffer_pkg;
  localparam int DEF_ROB_WIDTH_BIT = 3;
  localparam int DEF_REG_ID_BIT = 5;
  typedef enum logic [1:0] {
    ROB_TYPE_REG   = 2'b00,
    ROB_TYPE_BR    = 2'b01,
    ROB_TYPE_STORE = 2'b10
  } rob_type_t;
  function automatic rob_type_t decode_type(input logic [1:0] t);
    return t == 2'b11 ? ROB_TYPE_REG : rob_type_t'(t);
  endfunction
endpackage

// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order commit queue with CDB capture, operand lookup and mispredict flush
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_WIDTH_BIT = DEF_ROB_WIDTH_BIT,
  parameter int REG_ID_BIT = DEF_REG_ID_BIT
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     issue_en,
  input  logic [1:0]               issue_type,
  input  logic [REG_ID_BIT-1:0]    issue_rd,
  input  logic                     issue_pred_taken,
  input  logic                     issue_ready,
  input  logic [31:0]              issue_value,
  output logic [ROB_WIDTH_BIT-1:0] issue_id,
  output logic                     full,
  input  logic                     cdb_en,
  input  logic [ROB_WIDTH_BIT-1:0] cdb_id,
  input  logic [31:0]              cdb_value,
  input  logic                     cdb_taken,
  input  logic [ROB_WIDTH_BIT-1:0] q1_id,
  input  logic [ROB_WIDTH_BIT-1:0] q2_id,
  output logic                     q1_ready,
  output logic                     q2_ready,
  output logic [31:0]              q1_value,
  output logic [31:0]              q2_value,
  output logic                     write_en,
  output logic [REG_ID_BIT-1:0]    reg_id,
  output logic [ROB_WIDTH_BIT-1:0] rob_id,
  output logic [31:0]              value,
  output logic                     store_commit_en,
  output logic                     clear_all,
  output logic                     redirect_en,
  output logic [31:0]              redirect_pc
);
  localparam int DEPTH = 1 << ROB_WIDTH_BIT;
  localparam int CW = ROB_WIDTH_BIT + 1;
  logic [DEPTH-1:0] busy, done, pred, tkn;
  rob_type_t typ [DEPTH];
  logic [REG_ID_BIT-1:0] rd [DEPTH];
  logic [31:0] val [DEPTH];
  logic [ROB_WIDTH_BIT-1:0] head, tail;
  logic [CW-1:0] count;
  logic do_commit, flush, do_issue, do_cdb, q1_fwd, q2_fwd, q1_done, q2_done;
  assign issue_id = tail;
  assign full = count == CW'(DEPTH);
  assign do_commit = rdy_in & busy[head] & done[head];
  assign flush = do_commit & (typ[head] == ROB_TYPE_BR) & (tkn[head] != pred[head]);
  assign do_issue = rdy_in & issue_en & ~full & ~flush;
  assign do_cdb = rdy_in & cdb_en & busy[cdb_id] & ~flush;
  // Lookups forward a same-cycle broadcast so the decoder never misses a result
  always_comb begin
    q1_fwd = cdb_en & (cdb_id == q1_id);
    q2_fwd = cdb_en & (cdb_id == q2_id);
    q1_done = busy[q1_id] & done[q1_id];
    q2_done = busy[q2_id] & done[q2_id];
    q1_ready = q1_fwd | q1_done;
    q2_ready = q2_fwd | q2_done;
    q1_value = q1_fwd ? cdb_value : q1_done ? val[q1_id] : 32'd0;
    q2_value = q2_fwd ? cdb_value : q2_done ? val[q2_id] : 32'd0;
  end
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy <= '0;
      done <= '0;
      pred <= '0;
      tkn <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        typ[i] <= ROB_TYPE_REG;
        rd[i] <= '0;
        val[i] <= '0;
      end
      head <= '0;
      tail <= '0;
      count <= '0;
      write_en <= 1'b0;
      reg_id <= '0;
      rob_id <= '0;
      value <= '0;
      store_commit_en <= 1'b0;
      clear_all <= 1'b0;
      redirect_en <= 1'b0;
      redirect_pc <= '0;
    end else begin
      write_en <= 1'b0;
      store_commit_en <= 1'b0;
      clear_all <= 1'b0;
      redirect_en <= 1'b0;
      if (flush) begin
        busy <= '0;
        head <= '0;
        tail <= '0;
        count <= '0;
        clear_all <= 1'b1;
        redirect_en <= 1'b1;
        redirect_pc <= val[head];
      end else begin
        if (do_cdb) begin
          done[cdb_id] <= 1'b1;
          val[cdb_id] <= cdb_value;
          tkn[cdb_id] <= cdb_taken;
        end
        if (do_commit) begin
          busy[head] <= 1'b0;
          head <= head + 1'b1;
          if (typ[head] == ROB_TYPE_REG) begin
            write_en <= rd[head] != '0;
            reg_id <= rd[head];
            rob_id <= head;
            value <= val[head];
          end
          store_commit_en <= typ[head] == ROB_TYPE_STORE;
        end
        // Reserved type 11 retires as a reg-write that never writes
        if (do_issue) begin
          busy[tail] <= 1'b1;
          done[tail] <= issue_ready;
          typ[tail] <= decode_type(issue_type);
          rd[tail] <= issue_type == 2'b11 ? '0 : issue_rd;
          pred[tail] <= issue_pred_taken;
          tkn[tail] <= 1'b0;
          val[tail] <= issue_value;
          tail <= tail + 1'b1;
        end
        count <= count + CW'(do_issue) - CW'(do_commit);
      end
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed vectors with hand-computed expectations for reorder_buffer
module tb_reorder_buffer;
  logic clk_in = 1'b0, rst_in = 1'b1, rdy_in = 1'b1;
  logic issue_en = 1'b0, issue_pred_taken = 1'b0, issue_ready = 1'b0;
  logic [1:0] issue_type = 2'b00;
  logic [4:0] issue_rd = '0;
  logic [31:0] issue_value = '0;
  logic [2:0] issue_id;
  logic full;
  logic cdb_en = 1'b0, cdb_taken = 1'b0;
  logic [2:0] cdb_id = '0, q1_id = '0, q2_id = '0;
  logic [31:0] cdb_value = '0;
  logic q1_ready, q2_ready;
  logic [31:0] q1_value, q2_value;
  logic write_en, store_commit_en, clear_all, redirect_en;
  logic [4:0] reg_id;
  logic [2:0] rob_id;
  logic [31:0] value, redirect_pc;
  int vectors = 0, miscompares = 0;
  reorder_buffer dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .issue_en(issue_en), .issue_type(issue_type), .issue_rd(issue_rd),
    .issue_pred_taken(issue_pred_taken), .issue_ready(issue_ready), .issue_value(issue_value),
    .issue_id(issue_id), .full(full),
    .cdb_en(cdb_en), .cdb_id(cdb_id), .cdb_value(cdb_value), .cdb_taken(cdb_taken),
    .q1_id(q1_id), .q2_id(q2_id), .q1_ready(q1_ready), .q2_ready(q2_ready),
    .q1_value(q1_value), .q2_value(q2_value),
    .write_en(write_en), .reg_id(reg_id), .rob_id(rob_id), .value(value),
    .store_commit_en(store_commit_en), .clear_all(clear_all),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc)
  );
  always #5 clk_in = ~clk_in;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask
  task automatic issue(input logic [1:0] t, input logic [4:0] r, input logic rdy, input logic [31:0] v, input logic p);
    issue_en = 1'b1;
    issue_type = t;
    issue_rd = r;
    issue_ready = rdy;
    issue_value = v;
    issue_pred_taken = p;
    step();
    issue_en = 1'b0;
  endtask
  task automatic cdb(input logic [2:0] id, input logic [31:0] v, input logic t);
    cdb_en = 1'b1;
    cdb_id = id;
    cdb_value = v;
    cdb_taken = t;
    step();
    cdb_en = 1'b0;
  endtask
  initial begin
    #3;
    check("rst_issue_id", 32'(issue_id), 0);
    check("rst_full", 32'(full), 0);
    check("rst_write_en", 32'(write_en), 0);
    check("rst_clear_all", 32'(clear_all), 0);
    check("rst_value", value, 0);
    step();
    rst_in = 1'b0;
    // basic issue -> CDB -> commit
    issue(2'b00, 5'd5, 1'b0, 0, 1'b0);
    check("t1_issue_id", 32'(issue_id), 1);
    cdb(3'd0, 32'h1234, 1'b0);
    check("t1_pre_commit", 32'(write_en), 0);
    step();
    check("t1_write_en", 32'(write_en), 1);
    check("t1_reg_id", 32'(reg_id), 5);
    check("t1_rob_id", 32'(rob_id), 0);
    check("t1_value", value, 32'h1234);
    step();
    check("t1_pulse_end", 32'(write_en), 0);
    // fill to full, ids 1..7,0 carry rd 1..8
    for (int i = 0; i < 8; i++) issue(2'b00, 5'(i + 1), 1'b0, 0, 1'b0);
    check("t2_full", 32'(full), 1);
    check("t2_tail_wrap", 32'(issue_id), 1);
    issue(2'b00, 5'd20, 1'b0, 0, 1'b0);
    check("t2_ignored_tail", 32'(issue_id), 1);
    check("t2_still_full", 32'(full), 1);
    cdb(3'd1, 32'hA1, 1'b0);
    step();
    check("t2_commit_rob", 32'(rob_id), 1);
    check("t2_commit_val", value, 32'hA1);
    check("t2_not_full", 32'(full), 0);
    // out-of-order completion, in-order retire
    cdb(3'd4, 32'h204, 1'b0);
    cdb(3'd3, 32'h203, 1'b0);
    cdb(3'd2, 32'h202, 1'b0);
    step();
    check("t3_c0_rob", 32'(rob_id), 2);
    check("t3_c0_val", value, 32'h202);
    step();
    check("t3_c1_rob", 32'(rob_id), 3);
    check("t3_c1_reg", 32'(reg_id), 3);
    step();
    check("t3_c2_rob", 32'(rob_id), 4);
    check("t3_c2_en", 32'(write_en), 1);
    // drain remaining entries 5,6,7,0
    cdb(3'd5, 32'h205, 1'b0);
    cdb(3'd6, 32'h206, 1'b0);
    cdb(3'd7, 32'h207, 1'b0);
    cdb(3'd0, 32'h200, 1'b0);
    repeat (5) step();
    check("t4_drain_reg", 32'(reg_id), 8);
    check("t4_drain_val", value, 32'h200);
    check("t4_drain_idle", 32'(write_en), 0);
    check("t4_drain_tail", 32'(issue_id), 1);
    // mispredicted branch with two younger entries
    issue(2'b01, 5'd0, 1'b0, 0, 1'b0);
    issue(2'b00, 5'd9, 1'b0, 0, 1'b0);
    issue(2'b00, 5'd10, 1'b0, 0, 1'b0);
    cdb(3'd1, 32'h100, 1'b1);
    step();
    check("t4_clear_all", 32'(clear_all), 1);
    check("t4_redirect_en", 32'(redirect_en), 1);
    check("t4_redirect_pc", redirect_pc, 32'h100);
    check("t4_flush_tail", 32'(issue_id), 0);
    check("t4_flush_full", 32'(full), 0);
    check("t4_flush_no_write", 32'(write_en), 0);
    step();
    check("t4_clear_pulse", 32'(clear_all), 0);
    check("t4_redirect_pulse", 32'(redirect_en), 0);
    cdb(3'd2, 32'h99, 1'b0);
    step();
    check("t4_younger_dead", 32'(write_en), 0);
    // rd=0 ready-at-issue, then a store
    issue(2'b00, 5'd0, 1'b1, 32'h55, 1'b0);
    issue(2'b10, 5'd7, 1'b1, 0, 1'b0);
    check("t5_rd0_no_write", 32'(write_en), 0);
    check("t5_rd0_no_store", 32'(store_commit_en), 0);
    step();
    check("t5_store_commit", 32'(store_commit_en), 1);
    check("t5_store_no_write", 32'(write_en), 0);
    step();
    check("t5_store_pulse", 32'(store_commit_en), 0);
    // lookup forwarding, pause, async reset
    issue(2'b00, 5'd3, 1'b0, 0, 1'b0);
    issue(2'b00, 5'd4, 1'b0, 0, 1'b0);
    q1_id = 3'd3;
    q2_id = 3'd2;
    cdb_en = 1'b1;
    cdb_id = 3'd3;
    cdb_value = 32'd7;
    #1;
    check("t6_q1_fwd_ready", 32'(q1_ready), 1);
    check("t6_q1_fwd_value", q1_value, 7);
    check("t6_q2_not_ready", 32'(q2_ready), 0);
    check("t6_q2_zero", q2_value, 0);
    step();
    cdb_en = 1'b0;
    check("t6_q1_stored", q1_value, 7);
    cdb(3'd2, 32'h22, 1'b0);
    rdy_in = 1'b0;
    issue_en = 1'b1;
    issue_rd = 5'd11;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t6_pause_no_commit", 32'(write_en), 0);
    end
    check("t6_pause_no_issue", 32'(issue_id), 4);
    issue_en = 1'b0;
    rdy_in = 1'b1;
    step();
    check("t6_resume_en", 32'(write_en), 1);
    check("t6_resume_reg", 32'(reg_id), 3);
    check("t6_resume_val", value, 32'h22);
    step();
    check("t6_resume2_rob", 32'(rob_id), 3);
    check("t6_resume2_val", value, 7);
    #1;
    rst_in = 1'b1;
    #1;
    check("t6_arst_write_en", 32'(write_en), 0);
    check("t6_arst_value", value, 0);
    check("t6_arst_reg_id", 32'(reg_id), 0);
    check("t6_arst_issue_id", 32'(issue_id), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
